// File: rtl/trap_ctrl_pkg.sv
// Shared types and widths for the trap controller: state encoding,
// exception-code width and the 4-byte alignment helper.
package trap_ctrl_pkg;

    localparam int EX_WIDTH  = 4;
    localparam int ADDR_SIZE = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SAVE     = 2'd1,
        ST_REDIRECT = 2'd2
    } trap_state_e;

    // Trap vectors and return addresses are always word aligned.
    function automatic logic [ADDR_SIZE-1:0] align4(input logic [ADDR_SIZE-1:0] a);
        return {a[ADDR_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Trap entry / mret sequencer: IDLE -> SAVE -> REDIRECT for exceptions,
// IDLE -> REDIRECT for mret. Optional trap counter under TRAP_COUNT_EN.
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 exc_req,
    output logic                 exc_ack,
    input  logic [EX_WIDTH:0]    exc_cause,
    input  logic [31:0]          exc_pc,
    input  logic [31:0]          exc_tval,
    input  logic                 mret_req,
    output logic                 mret_ack,
    input  logic [31:0]          csr_mtvec,
    input  logic [31:0]          csr_mepc,
    output logic                 csr_we,
    output logic [31:0]          mepc_wdata,
    output logic [31:0]          mcause_wdata,
    output logic [31:0]          mtval_wdata,
    output logic                 flush,
    output logic [31:0]          flush_addr,
    input  logic                 fetch_ready,
`ifdef TRAP_COUNT_EN
    output logic [31:0]          trap_count,
`endif
    output logic                 csr_busy
);

    trap_state_e        state_q;
    logic [31:0]        pc_q;
    logic [EX_WIDTH:0]  cause_q;
    logic [31:0]        tval_q;
    logic [31:0]        target_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            cause_q  <= '0;
            tval_q   <= '0;
            target_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (exc_req) begin
                        pc_q    <= exc_pc;
                        cause_q <= exc_cause;
                        tval_q  <= exc_tval;
                        state_q <= ST_SAVE;
                    end else if (mret_req) begin
                        target_q <= align4(csr_mepc);
                        state_q  <= ST_REDIRECT;
                    end
                end
                ST_SAVE: begin
                    // mtvec is sampled here, not at accept, so a CSR write
                    // retiring alongside the trap is honoured.
                    target_q <= align4(csr_mtvec);
                    state_q  <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (fetch_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef TRAP_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (reset)                  count_q <= '0;
        else if (state_q == ST_SAVE) count_q <= count_q + 32'd1;
    end

    assign trap_count = reset ? 32'd0 : count_q;
`endif

    // Every output is forced low while reset is high, which also drops a
    // CSR write that was in flight when reset hit.
    logic in_idle, in_save, in_redir;

    assign in_idle  = (state_q == ST_IDLE)     && !reset;
    assign in_save  = (state_q == ST_SAVE)     && !reset;
    assign in_redir = (state_q == ST_REDIRECT) && !reset;

    assign exc_ack      = in_idle && exc_req;
    assign mret_ack     = in_idle && mret_req && !exc_req;
    assign csr_busy     = (state_q != ST_IDLE) && !reset;

    assign csr_we       = in_save;
    assign mepc_wdata   = in_save ? align4(pc_q) : 32'd0;
    assign mcause_wdata = in_save ? {{(31-EX_WIDTH){1'b0}}, cause_q} : 32'd0;
    assign mtval_wdata  = in_save ? tval_q : 32'd0;

    assign flush        = in_redir;
    assign flush_addr   = in_redir ? target_q : 32'd0;

endmodule
